// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one 16-bit Galois LFSR, deliveries spaced by at least GAP steps.
// Optional RNG_ZERO_GUARD_EN: an all-zero LFSR state or zero reseed is replaced by RESET_SEED.
module rng_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          GAP        = 16,
    parameter logic [15:0] RESET_SEED = 16'hABCD
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [15:0]        seed_in,
    input  logic               seed_load_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [15:0]        rand_out,
    output logic               rand_valid_out,
    output logic               busy_out
);
    localparam int            PW       = $clog2(NUM_REQ);
    localparam logic [7:0]    GAP_C    = 8'(GAP);
    localparam logic [PW-1:0] LAST_RST = PW'(NUM_REQ - 1);

    logic [15:0]        lfsr_q, lfsr_d, lfsr_raw, lfsr_step, seed_eff;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [PW-1:0]      last_ptr_q, last_ptr_d, winner, idx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [15:0]        rand_q, rand_d;
    logic               valid_q, valid_d, grant;

    assign lfsr_raw = {lfsr_q[15] ^ lfsr_q[14], lfsr_q[13:2], lfsr_q[1] ^ lfsr_q[15], lfsr_q[0], lfsr_q[15]};
`ifdef RNG_ZERO_GUARD_EN
    assign lfsr_step = (lfsr_q == '0) ? RESET_SEED : lfsr_raw;
    assign seed_eff  = (seed_in == '0) ? RESET_SEED : seed_in;
`else
    assign lfsr_step = lfsr_raw;
    assign seed_eff  = seed_in;
`endif

    // Scan farthest-first so the nearest requester after last_ptr overwrites the winner.
    always_comb begin
        winner = last_ptr_q;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(last_ptr_q) + k) % NUM_REQ);
            if (req_in[idx]) winner = idx;
        end
    end

    assign grant = !seed_load_in && (step_cnt_q == GAP_C) && (|req_in);

    always_comb begin
        step_cnt_d = (grant || seed_load_in) ? '0 : ((step_cnt_q == GAP_C) ? step_cnt_q : step_cnt_q + 8'd1);
        lfsr_d     = seed_load_in ? seed_eff : lfsr_step;
        last_ptr_d = grant ? winner : last_ptr_q;
        gnt_d      = grant ? (NUM_REQ'(1) << winner) : '0;
        valid_d    = grant;
        rand_d     = grant ? lfsr_q : rand_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            lfsr_q     <= RESET_SEED;
            step_cnt_q <= '0;
            last_ptr_q <= LAST_RST;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            rand_q     <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            step_cnt_q <= step_cnt_d;
            last_ptr_q <= last_ptr_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            rand_q     <= rand_d;
        end
    end

    assign gnt_out        = gnt_q;
    assign rand_out       = rand_q;
    assign rand_valid_out = valid_q;
    assign busy_out       = step_cnt_q < GAP_C;
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: scoreboard bench for rng_arbiter against a spec-level LFSR/arbitration model.
module tb_rng_arbiter;
    localparam int          N   = 4;
    localparam int          GAP = 16;
    localparam logic [15:0] RS  = 16'hABCD;
`ifdef RNG_ZERO_GUARD_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         vld;
        logic [15:0]  rv;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, seed_load;
    logic [N-1:0] req, gnt;
    logic [15:0]  seed, rnd;
    logic         vld, busy;
    logic         rst1_n;
    logic [N-1:0] req1, gnt1;
    logic [15:0]  rnd1;
    logic         vld1, busy1;

    exp_t         sbq[$];
    bit           mon_on = 1'b0;
    int           n_cmp = 0, n_err = 0;

    logic [15:0]  m_lfsr, m_rand;
    int           m_cnt, m_last;
    logic [N-1:0] m_gnt, pend;
    bit           m_vld;

    initial forever #5 clk = ~clk;

    rng_arbiter #(.NUM_REQ(N), .GAP(GAP), .RESET_SEED(RS)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .seed_in(seed), .seed_load_in(seed_load),
        .gnt_out(gnt), .rand_out(rnd), .rand_valid_out(vld), .busy_out(busy));

    rng_arbiter #(.NUM_REQ(N), .GAP(1), .RESET_SEED(RS)) dut1 (
        .clk_in(clk), .rst_n_in(rst1_n), .req_in(req1), .seed_in(16'h0000), .seed_load_in(1'b0),
        .gnt_out(gnt1), .rand_out(rnd1), .rand_valid_out(vld1), .busy_out(busy1));

    function automatic logic [15:0] lstep(input logic [15:0] q);
        return {q[14:0], q[15]} ^ (q[15] ? 16'h8004 : 16'h0000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and push what the DUT must show after the coming edge.
    task automatic drive(input logic [N-1:0] r, input bit sl, input logic [15:0] sd, input bit rs);
        bit g;
        @(negedge clk);
        req = r; seed_load = sl; seed = sd; rst_n = !rs;
        if (rs) begin
            m_lfsr = RS; m_cnt = 0; m_last = N - 1; m_gnt = '0; m_vld = 0; m_rand = '0;
        end else begin
            g = !sl && m_cnt == GAP && r != '0;
            m_gnt = '0;
            m_vld = g;
            if (g) begin
                m_rand = m_lfsr;
                for (int k = 1; k <= N; k++) begin
                    int i = (m_last + k) % N;
                    if (r[i]) begin
                        m_gnt[i] = 1'b1;
                        m_last = i;
                        break;
                    end
                end
            end
            m_cnt = (g || sl) ? 0 : (m_cnt < GAP ? m_cnt + 1 : GAP);
            if (sl) m_lfsr = (ZG && sd == 16'h0) ? RS : sd;
            else    m_lfsr = (ZG && m_lfsr == 16'h0) ? RS : lstep(m_lfsr);
        end
        sbq.push_back('{gnt: m_gnt, vld: m_vld, rv: m_rand, busy: (m_cnt < GAP)});
        mon_on = 1'b1;
    endtask

    task automatic serve(input int ngr);
        int got = 0;
        for (int t = 0; t < 400 && got < ngr; t++) begin
            drive(pend, 0, 16'h0, 0);
            if (m_vld) begin
                pend &= ~m_gnt;
                got++;
            end
        end
        if (got < ngr) chk("serve_timeout", got, ngr);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_underflow: got no expectation at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("valid", vld, e.vld);
                    chk("gnt", gnt, e.gnt);
                    chk("rand", rnd, e.rv);
                    chk("busy", busy, e.busy);
                end
            end
        end
    end

    initial begin
        int r;
        bit sl, rs;
        logic [15:0] sd;
        rst_n = 0; req = '0; seed_load = 0; seed = '0;
        rst1_n = 0; req1 = '0;
        @(negedge clk);
        chk("g1_rst_busy", busy1, 1);
        chk("g1_rst_gnt", gnt1, 0);
        chk("g1_rst_valid", vld1, 0);
        chk("g1_rst_rand", rnd1, 0);
        rst1_n = 1; req1 = 4'b0001;
        @(negedge clk);
        chk("g1_e1_gnt", gnt1, 0);
        chk("g1_e1_valid", vld1, 0);
        @(negedge clk);
        chk("g1_e2_gnt", gnt1, 4'b0001);
        chk("g1_e2_valid", vld1, 1);
        chk("g1_e2_rand", rnd1, 16'hD79F);

        drive('0, 0, 16'h0, 1);
        for (int c = 0; c < 17 * 5; c++) drive(4'hF, 0, 16'h0, 0);
        for (int c = 0; c < 200 && m_last != 3; c++) drive(4'hF, 0, 16'h0, 0);
        pend = 4'b0101; serve(2);
        pend = 4'b0101; serve(1);
        pend = 4'b0001; serve(1);

        for (int c = 0; c < 40 && m_cnt != GAP; c++) drive(4'hF, 0, 16'h0, 0);
        drive(4'hF, 1, 16'h1234, 0);
        pend = 4'hF; serve(1);

        pend = 4'hF; serve(1);
        drive(4'hF, 0, 16'h0, 1);
        pend = 4'b0001; serve(1);

        drive('0, 1, 16'h0000, 0);
        pend = 4'b0001; serve(1);
        drive('0, 1, 16'h5A5A, 0);

        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            r  = $urandom_range(0, 99);
            rs = r < 1;
            sl = r >= 1 && r < 4;
            sd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            pend |= N'($urandom) & N'($urandom);
            if ($urandom_range(0, 15) == 0) pend &= N'($urandom);
            drive(pend, sl, sd, rs);
            if (m_vld) pend &= ~m_gnt;
        end

        @(posedge clk);
        #2;
        mon_on = 1'b0;
        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
